// File: rtl/hazard_pkg.sv
// Shared encodings and helpers for the scoreboard-based hazard unit.
package hazard_pkg;

  localparam logic [1:0] CLS_ALU  = 2'b00;
  localparam logic [1:0] CLS_LOAD = 2'b01;
  localparam logic [1:0] CLS_LONG = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_COUNT  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_LONG   = 2'd3
  } entry_state_e;

  // Cycles after issue until the result can be forwarded into EX; the reserved
  // class behaves like ALU and LONG never uses the countdown.
  function automatic int class_latency(input logic [1:0] cls, input int alu_lat,
                                       input int load_lat);
    return (cls == CLS_LOAD) ? load_lat : alu_lat;
  endfunction

endpackage

// File: rtl/scoreboard_entry.sv
// Tracks the in-flight producer of one architectural register and reports
// when its value can be consumed in ID, in EX, or as store data.
module scoreboard_entry
  import hazard_pkg::*;
#(
  parameter int LAT_W = 3
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             issue,
  input  logic             issue_long,
  input  logic [LAT_W-1:0] issue_lat,
  input  logic             long_complete,
  output logic             ready_id,
  output logic             ready_ex,
  output logic             ready_st,
  output logic             is_long
);

  entry_state_e     state_reg;
  logic [LAT_W-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
    end else if (flush) begin
      state_reg <= ST_IDLE;
    end else if (issue) begin
      if (issue_long) begin
        state_reg <= ST_LONG;
      end else if (issue_lat == '0) begin
        state_reg <= ST_SETTLE;
      end else begin
        state_reg <= ST_COUNT;
        cnt_reg   <= issue_lat;
      end
    end else begin
      case (state_reg)
        ST_COUNT: begin
          if (cnt_reg < LAT_W'(2)) state_reg <= ST_SETTLE;
          else                     cnt_reg   <= cnt_reg - LAT_W'(1);
        end
        ST_SETTLE: state_reg <= ST_IDLE;
        ST_LONG:   if (long_complete) state_reg <= ST_SETTLE;
        default:   state_reg <= ST_IDLE;
      endcase
    end
  end

  assign ready_id = (state_reg == ST_IDLE);
  assign ready_ex = ready_id || (state_reg == ST_SETTLE);
  // Last countdown cycle: the value reaches WB in time for the store's MEM stage.
  assign ready_st = ready_ex || (state_reg == ST_COUNT && cnt_reg == LAT_W'(1));
  assign is_long  = (state_reg == ST_LONG);

endmodule

// File: rtl/hazard_scoreboard.sv
// Per-register scoreboard hazard unit beside ID: stall, IF/ID flush, ID/EX
// bubble, long-unit interlocks, global flush and a saturating stall counter.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int REG_AW   = 5,
  parameter int LAT_W    = 3,
  parameter int ALU_LAT  = 0,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic              id_is_store,
  input  logic              id_resolves_in_id,
  input  logic              id_regwrite,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [1:0]        id_class,
  input  logic              long_done,
  input  logic [REG_AW-1:0] long_done_rd,
  input  logic              branch_taken,
  input  logic              flush_all,
  output logic              stall,
  output logic              flush_ifid,
  output logic              flush_idex,
  output logic              long_busy,
  output logic [CNT_W-1:0]  stall_count,
  output logic              done_err
);

  logic [NUM_REGS-1:0] rdy_id, rdy_ex, rdy_st, long_vec;
  logic [REG_AW-1:0]   long_rd;
  logic [LAT_W-1:0]    issue_lat;
  logic                issue, issue_long, long_ok;
  logic                rs1_ok, rs2_ok, rs1_haz, rs2_haz, waw_haz, struct_haz;

  assign issue_long = (id_class == CLS_LONG);
  assign issue_lat  = LAT_W'(class_latency(id_class, ALU_LAT, LOAD_LAT));
  assign issue      = id_valid && !stall && !flush_all && id_regwrite && (id_rd != '0);
  assign long_ok    = long_done && !flush_all && long_busy && (long_done_rd == long_rd);

  // x0 has no producer to wait for.
  assign rdy_id[0]   = 1'b1;
  assign rdy_ex[0]   = 1'b1;
  assign rdy_st[0]   = 1'b1;
  assign long_vec[0] = 1'b0;

  genvar gi;
  generate
    for (gi = 1; gi < NUM_REGS; gi++) begin : g_entry
      scoreboard_entry #(.LAT_W(LAT_W)) u_entry (
        .clk          (clk),
        .rstn         (rstn),
        .flush        (flush_all),
        .issue        (issue && (id_rd == REG_AW'(gi))),
        .issue_long   (issue_long),
        .issue_lat    (issue_lat),
        .long_complete(long_ok && (long_rd == REG_AW'(gi))),
        .ready_id     (rdy_id[gi]),
        .ready_ex     (rdy_ex[gi]),
        .ready_st     (rdy_st[gi]),
        .is_long      (long_vec[gi])
      );
    end
  endgenerate

  always_comb begin
    rs1_ok = id_resolves_in_id ? rdy_id[id_rs1] : rdy_ex[id_rs1];
    if (id_resolves_in_id)
      rs2_ok = rdy_id[id_rs2];
    else if (id_is_store && !(id_use_rs1 && id_rs1 == id_rs2))
      rs2_ok = rdy_st[id_rs2];
    else
      rs2_ok = rdy_ex[id_rs2];
  end

  assign rs1_haz    = id_use_rs1 && !rs1_ok;
  assign rs2_haz    = id_use_rs2 && !rs2_ok;
  assign waw_haz    = id_regwrite && (id_rd != '0) && long_vec[id_rd];
  assign struct_haz = issue_long && long_busy;

  assign stall      = id_valid && !flush_all && (rs1_haz || rs2_haz || waw_haz || struct_haz);
  assign flush_idex = stall || flush_all;
  assign flush_ifid = (branch_taken && !stall) || flush_all;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      long_busy   <= 1'b0;
      long_rd     <= '0;
      stall_count <= '0;
      done_err    <= 1'b0;
    end else begin
      if (flush_all) begin
        long_busy <= 1'b0;
      end else if (issue && issue_long) begin
        long_busy <= 1'b1;
        long_rd   <= id_rd;
      end else if (long_ok) begin
        long_busy <= 1'b0;
      end
      // A completion racing a flush belongs to killed work, so it is not an error.
      if (long_done && !flush_all && !long_ok) done_err <= 1'b1;
      if (stall && stall_count != '1) stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scenario bench for hazard_scoreboard: expected outputs are queued as each
// cycle is driven and popped when the outputs are sampled on the falling edge.
module tb_hazard_scoreboard;
  import hazard_pkg::*;

  localparam int TB_CNT_W = 3;
  localparam logic [TB_CNT_W-1:0] SAT = '1;
  localparam logic [4:0] F_ST = 5'b10000, F_RID = 5'b01000, F_BT = 5'b00100,
                         F_FA = 5'b00010, F_LD = 5'b00001, F_NONE = 5'b00000;

  logic clk = 1'b0, rstn = 1'b0;
  logic id_valid = 0, id_use_rs1 = 0, id_use_rs2 = 0, id_is_store = 0;
  logic id_resolves_in_id = 0, id_regwrite = 0, long_done = 0, branch_taken = 0, flush_all = 0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0, long_done_rd = '0;
  logic [1:0] id_class = CLS_ALU;
  logic stall, flush_ifid, flush_idex, long_busy, done_err;
  logic [TB_CNT_W-1:0] stall_count;

  hazard_scoreboard #(.CNT_W(TB_CNT_W)) dut (
    .clk(clk), .rstn(rstn), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_is_store(id_is_store),
    .id_resolves_in_id(id_resolves_in_id), .id_regwrite(id_regwrite), .id_rd(id_rd),
    .id_class(id_class), .long_done(long_done), .long_done_rd(long_done_rd),
    .branch_taken(branch_taken), .flush_all(flush_all), .stall(stall),
    .flush_ifid(flush_ifid), .flush_idex(flush_idex), .long_busy(long_busy),
    .stall_count(stall_count), .done_err(done_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic v; logic [4:0] rs1; logic u1; logic [4:0] rs2; logic u2;
    logic rw; logic [4:0] rd; logic [1:0] cls; logic [4:0] fl; logic [4:0] ldrd;
    logic [4:0] ex;  // {stall, flush_ifid, flush_idex, long_busy, done_err}
  } cyc_t;

  int checks = 0, failures = 0;
  logic [4:0] exp_q[$];
  logic [TB_CNT_W-1:0] cnt_model = '0;

  function automatic cyc_t mk(input logic v, input logic [4:0] rs1, input logic u1,
                              input logic [4:0] rs2, input logic u2, input logic rw,
                              input logic [4:0] rd, input logic [1:0] cls,
                              input logic [4:0] fl, input logic [4:0] ldrd,
                              input logic [4:0] ex);
    cyc_t c;
    c.v = v; c.rs1 = rs1; c.u1 = u1; c.rs2 = rs2; c.u2 = u2; c.rw = rw;
    c.rd = rd; c.cls = cls; c.fl = fl; c.ldrd = ldrd; c.ex = ex;
    return c;
  endfunction

  function automatic cyc_t idle(input logic [4:0] fl, input logic [4:0] ldrd, input logic [4:0] ex);
    return mk(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, CLS_ALU, fl, ldrd, ex);
  endfunction

  task automatic drive(input cyc_t c);
    @(posedge clk); #1;
    id_valid = c.v; id_rs1 = c.rs1; id_use_rs1 = c.u1; id_rs2 = c.rs2; id_use_rs2 = c.u2;
    id_regwrite = c.rw; id_rd = c.rd; id_class = c.cls; long_done_rd = c.ldrd;
    {id_is_store, id_resolves_in_id, branch_taken, flush_all, long_done} = c.fl;
    exp_q.push_back(c.ex);
  endtask

  task automatic test_reset();
    logic [7:0] got;
    @(negedge clk);
    got = {stall, flush_ifid, flush_idex, long_busy, done_err, stall_count};
    checks++;
    if (got !== 8'h00) begin
      $display("FAIL reset outs got=%b want=%b", got, 8'h00); failures++;
    end
    $display("reset outs=%b", got);
    rstn = 1'b1;
  endtask

  task automatic test_load_use();
    cyc_t seq[$]; logic [4:0] got, want;
    seq.push_back(mk(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd5,  CLS_LOAD, F_NONE, 5'd0, 5'b00000));
    seq.push_back(mk(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 5'd10, CLS_ALU,  F_NONE, 5'd0, 5'b10100));
    seq.push_back(mk(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 5'd10, CLS_ALU,  F_NONE, 5'd0, 5'b00000));
    seq.push_back(idle(F_NONE, 5'd0, 5'b00000));
    foreach (seq[i]) begin
      drive(seq[i]); @(negedge clk);
      got = {stall, flush_ifid, flush_idex, long_busy, done_err}; want = exp_q.pop_front();
      checks++;
      if (got !== want) begin $display("FAIL load_use[%0d] outs got=%b want=%b", i, got, want); failures++; end
      checks++;
      if (stall_count !== cnt_model) begin $display("FAIL load_use[%0d] stall_count got=%0d want=%0d", i, stall_count, cnt_model); failures++; end
      if (want[4] && cnt_model != SAT) cnt_model++;
      $display("load_use[%0d] outs=%b cnt=%0d", i, got, stall_count);
    end
  endtask

  task automatic test_branch_load();
    cyc_t seq[$]; logic [4:0] got, want;
    seq.push_back(mk(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd5, CLS_LOAD, F_NONE, 5'd0, 5'b00000));
    for (int k = 0; k < 3; k++)
      seq.push_back(mk(1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0, 5'd0, CLS_ALU, F_RID | F_BT, 5'd0,
                       (k < 2) ? 5'b10100 : 5'b01000));
    seq.push_back(idle(F_NONE, 5'd0, 5'b00000));
    foreach (seq[i]) begin
      drive(seq[i]); @(negedge clk);
      got = {stall, flush_ifid, flush_idex, long_busy, done_err}; want = exp_q.pop_front();
      checks++;
      if (got !== want) begin $display("FAIL branch_load[%0d] outs got=%b want=%b", i, got, want); failures++; end
      checks++;
      if (stall_count !== cnt_model) begin $display("FAIL branch_load[%0d] stall_count got=%0d want=%0d", i, stall_count, cnt_model); failures++; end
      if (want[4] && cnt_model != SAT) cnt_model++;
      $display("branch_load[%0d] outs=%b cnt=%0d", i, got, stall_count);
    end
  endtask

  task automatic test_branch_alu();
    cyc_t seq[$]; logic [4:0] got, want;
    seq.push_back(mk(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 5'd7, CLS_ALU, F_NONE, 5'd0, 5'b00000));
    seq.push_back(mk(1'b1, 5'd7, 1'b1, 5'd0, 1'b1, 1'b0, 5'd0, CLS_ALU, F_RID | F_BT, 5'd0, 5'b10100));
    seq.push_back(mk(1'b1, 5'd7, 1'b1, 5'd0, 1'b1, 1'b0, 5'd0, CLS_ALU, F_RID | F_BT, 5'd0, 5'b01000));
    // A load targeting x0 must not create any tracking.
    seq.push_back(mk(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd0, CLS_LOAD, F_NONE, 5'd0, 5'b00000));
    seq.push_back(mk(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 5'd0, CLS_ALU, F_RID, 5'd0, 5'b00000));
    foreach (seq[i]) begin
      drive(seq[i]); @(negedge clk);
      got = {stall, flush_ifid, flush_idex, long_busy, done_err}; want = exp_q.pop_front();
      checks++;
      if (got !== want) begin $display("FAIL branch_alu[%0d] outs got=%b want=%b", i, got, want); failures++; end
      checks++;
      if (stall_count !== cnt_model) begin $display("FAIL branch_alu[%0d] stall_count got=%0d want=%0d", i, stall_count, cnt_model); failures++; end
      if (want[4] && cnt_model != SAT) cnt_model++;
      $display("branch_alu[%0d] outs=%b cnt=%0d", i, got, stall_count);
    end
  endtask

  task automatic test_store_fwd();
    cyc_t seq[$]; logic [4:0] got, want;
    seq.push_back(mk(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd8, CLS_LOAD, F_NONE, 5'd0, 5'b00000));
    seq.push_back(mk(1'b1, 5'd2, 1'b1, 5'd8, 1'b1, 1'b0, 5'd0, CLS_ALU,  F_ST,   5'd0, 5'b00000));
    seq.push_back(idle(F_NONE, 5'd0, 5'b00000));
    seq.push_back(idle(F_NONE, 5'd0, 5'b00000));
    seq.push_back(mk(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd8, CLS_LOAD, F_NONE, 5'd0, 5'b00000));
    seq.push_back(mk(1'b1, 5'd8, 1'b1, 5'd2, 1'b1, 1'b0, 5'd0, CLS_ALU,  F_ST,   5'd0, 5'b10100));
    seq.push_back(mk(1'b1, 5'd8, 1'b1, 5'd2, 1'b1, 1'b0, 5'd0, CLS_ALU,  F_ST,   5'd0, 5'b00000));
    seq.push_back(idle(F_NONE, 5'd0, 5'b00000));
    foreach (seq[i]) begin
      drive(seq[i]); @(negedge clk);
      got = {stall, flush_ifid, flush_idex, long_busy, done_err}; want = exp_q.pop_front();
      checks++;
      if (got !== want) begin $display("FAIL store_fwd[%0d] outs got=%b want=%b", i, got, want); failures++; end
      checks++;
      if (stall_count !== cnt_model) begin $display("FAIL store_fwd[%0d] stall_count got=%0d want=%0d", i, stall_count, cnt_model); failures++; end
      if (want[4] && cnt_model != SAT) cnt_model++;
      $display("store_fwd[%0d] outs=%b cnt=%0d", i, got, stall_count);
    end
  endtask

  task automatic test_long();
    cyc_t seq[$]; logic [4:0] got, want;
    seq.push_back(mk(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd9,  CLS_LONG, F_NONE, 5'd0, 5'b00000));
    seq.push_back(mk(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 1'b1, 5'd11, CLS_ALU,  F_NONE, 5'd0, 5'b10110));
    seq.push_back(mk(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 1'b1, 5'd11, CLS_ALU,  F_NONE, 5'd0, 5'b10110));
    seq.push_back(mk(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 1'b1, 5'd11, CLS_ALU,  F_LD,   5'd9, 5'b10110));
    seq.push_back(mk(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 1'b1, 5'd11, CLS_ALU,  F_NONE, 5'd0, 5'b00000));
    seq.push_back(mk(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd12, CLS_LONG, F_NONE, 5'd0, 5'b00000));
    seq.push_back(mk(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd13, CLS_LONG, F_NONE, 5'd0, 5'b10110));
    seq.push_back(mk(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd12, CLS_ALU,  F_NONE, 5'd0, 5'b10110));
    seq.push_back(idle(F_LD,   5'd3,  5'b00010));
    seq.push_back(idle(F_LD,   5'd12, 5'b00011));
    seq.push_back(idle(F_NONE, 5'd0,  5'b00001));
    seq.push_back(idle(F_NONE, 5'd0,  5'b00001));
    foreach (seq[i]) begin
      drive(seq[i]); @(negedge clk);
      got = {stall, flush_ifid, flush_idex, long_busy, done_err}; want = exp_q.pop_front();
      checks++;
      if (got !== want) begin $display("FAIL long[%0d] outs got=%b want=%b", i, got, want); failures++; end
      checks++;
      if (stall_count !== cnt_model) begin $display("FAIL long[%0d] stall_count got=%0d want=%0d", i, stall_count, cnt_model); failures++; end
      if (want[4] && cnt_model != SAT) cnt_model++;
      $display("long[%0d] outs=%b cnt=%0d", i, got, stall_count);
    end
  endtask

  task automatic test_flush();
    cyc_t seq[$]; logic [4:0] got, want;
    rstn = 1'b0; #2; rstn = 1'b1; cnt_model = '0;
    seq.push_back(mk(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd9,  CLS_LONG, F_NONE, 5'd0, 5'b00000));
    seq.push_back(mk(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd5,  CLS_LOAD, F_NONE, 5'd0, 5'b00010));
    seq.push_back(mk(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 1'b1, 5'd14, CLS_ALU,  F_FA | F_LD, 5'd9, 5'b01110));
    seq.push_back(mk(1'b1, 5'd9, 1'b1, 5'd5, 1'b1, 1'b0, 5'd0,  CLS_ALU,  F_RID,  5'd0, 5'b00000));
    seq.push_back(idle(F_LD,   5'd9, 5'b00000));
    seq.push_back(idle(F_NONE, 5'd0, 5'b00001));
    foreach (seq[i]) begin
      drive(seq[i]); @(negedge clk);
      got = {stall, flush_ifid, flush_idex, long_busy, done_err}; want = exp_q.pop_front();
      checks++;
      if (got !== want) begin $display("FAIL flush[%0d] outs got=%b want=%b", i, got, want); failures++; end
      checks++;
      if (stall_count !== cnt_model) begin $display("FAIL flush[%0d] stall_count got=%0d want=%0d", i, stall_count, cnt_model); failures++; end
      if (want[4] && cnt_model != SAT) cnt_model++;
      $display("flush[%0d] outs=%b cnt=%0d", i, got, stall_count);
    end
  endtask

  task automatic test_reset_mid();
    cyc_t seq[$]; logic [4:0] got, want; logic [7:0] all;
    seq.push_back(mk(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd5,  CLS_LOAD, F_NONE, 5'd0, 5'b00001));
    seq.push_back(mk(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 5'd10, CLS_ALU,  F_NONE, 5'd0, 5'b10101));
    foreach (seq[i]) begin
      drive(seq[i]); @(negedge clk);
      got = {stall, flush_ifid, flush_idex, long_busy, done_err}; want = exp_q.pop_front();
      checks++;
      if (got !== want) begin $display("FAIL reset_mid[%0d] outs got=%b want=%b", i, got, want); failures++; end
      checks++;
      if (stall_count !== cnt_model) begin $display("FAIL reset_mid[%0d] stall_count got=%0d want=%0d", i, stall_count, cnt_model); failures++; end
      if (want[4] && cnt_model != SAT) cnt_model++;
      $display("reset_mid[%0d] outs=%b cnt=%0d", i, got, stall_count);
    end
    rstn = 1'b0; #2;
    all = {stall, flush_ifid, flush_idex, long_busy, done_err, stall_count};
    checks++;
    if (all !== 8'h00) begin $display("FAIL reset_mid async outs got=%b want=%b", all, 8'h00); failures++; end
    $display("reset_mid async outs=%b", all);
    rstn = 1'b1; cnt_model = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load_use();
    test_branch_load();
    test_branch_alu();
    test_store_fwd();
    test_long();
    test_flush();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
